// File: rtl/game_round_pkg.sv
// Shared definitions for the game round controller: state encoding,
// parameter defaults and fixed output widths.
package game_round_pkg;

  localparam int LEVEL_W = 3;
  localparam int LIVES_W = 3;

  localparam int DEF_LIVES_INIT     = 3;
  localparam int DEF_WINS_PER_LEVEL = 4;
  localparam int DEF_MAX_LEVEL      = 7;
  localparam int DEF_BASE_SPEED     = 1;
  localparam int DEF_DXY_W          = 4;
  localparam int DEF_SCORE_W        = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ARM       = 3'd1,
    ST_PLAY      = 3'd2,
    ST_LEVEL_UP  = 3'd3,
    ST_GAME_OVER = 3'd4
  } state_t;

endpackage

// File: rtl/game_sat_counter.sv
// Up counter that sticks at all-ones; synchronous clear wins over increment.
module game_sat_counter #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_reset_n,
  input  logic         i_clear,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_inc && (r_count != {W{1'b1}})) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/game_round_controller.sv
// Session sequencer above the game master: lives, score, level, high score,
// per-level target speed, and the hold that parks the master between games.
module game_round_controller
  import game_round_pkg::*;
#(
  parameter int LIVES_INIT     = DEF_LIVES_INIT,
  parameter int WINS_PER_LEVEL = DEF_WINS_PER_LEVEL,
  parameter int MAX_LEVEL      = DEF_MAX_LEVEL,
  parameter int BASE_SPEED     = DEF_BASE_SPEED,
  parameter int DXY_W          = DEF_DXY_W,
  parameter int SCORE_W        = DEF_SCORE_W
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic               i_key,
  input  logic               i_round_done,
  input  logic               i_round_won,
  input  logic               i_end_of_game_timer_running,
  output logic               o_master_hold,
  output logic [DXY_W-1:0]   o_target_speed,
  output logic [LEVEL_W-1:0] o_level,
  output logic [LIVES_W-1:0] o_lives,
  output logic [SCORE_W-1:0] o_score,
  output logic [SCORE_W-1:0] o_high_score,
  output logic               o_level_up,
  output logic               o_game_over
);

  localparam int WIN_W = (WINS_PER_LEVEL > 1) ? $clog2(WINS_PER_LEVEL) : 1;
  localparam logic [WIN_W-1:0]   WIN_LAST    = WIN_W'(WINS_PER_LEVEL - 1);
  localparam logic [LEVEL_W-1:0] LEVEL_MAX   = LEVEL_W'(MAX_LEVEL);
  localparam logic [LIVES_W-1:0] LIVES_START = LIVES_W'(LIVES_INIT);
  localparam logic [DXY_W-1:0]   SPEED_BASE  = DXY_W'(BASE_SPEED);

  state_t               r_state;
  logic                 r_key_q;
  logic [WIN_W-1:0]     r_win_count;
  logic [LEVEL_W-1:0]   r_level;
  logic [LIVES_W-1:0]   r_lives;
  logic [SCORE_W-1:0]   r_high_score;
  logic [DXY_W-1:0]     r_target_speed;
  logic                 r_master_hold;
  logic                 r_level_up;
  logic                 r_game_over;

  state_t               w_state_next;
  logic [WIN_W-1:0]     w_win_count_next;
  logic [LEVEL_W-1:0]   w_level_next;
  logic [LIVES_W-1:0]   w_lives_next;
  logic [SCORE_W-1:0]   w_high_score_next;
  logic [DXY_W-1:0]     w_target_speed_next;
  logic [LEVEL_W-1:0]   w_level_inc;
  logic [SCORE_W-1:0]   w_score;
  logic                 w_key_rise;
  logic                 w_start;
  logic                 w_score_clear;
  logic                 w_score_inc;

  assign w_key_rise  = i_key & ~r_key_q;
  assign w_level_inc = (r_level < LEVEL_MAX) ? (r_level + LEVEL_W'(1)) : LEVEL_MAX;

  always_comb begin
    w_state_next        = r_state;
    w_win_count_next    = r_win_count;
    w_level_next        = r_level;
    w_lives_next        = r_lives;
    w_high_score_next   = r_high_score;
    w_target_speed_next = r_target_speed;
    w_start             = 1'b0;
    w_score_inc         = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_key_rise) begin
          w_start = 1'b1;
        end
      end
      ST_ARM: begin
        // Wait for the start press to be released so it cannot fire a torpedo.
        if (!i_key) begin
          w_state_next = ST_PLAY;
        end
      end
      ST_PLAY: begin
        if (i_round_done && i_round_won) begin
          w_score_inc = 1'b1;
          if (r_win_count == WIN_LAST) begin
            w_win_count_next = '0;
            if (r_level < LEVEL_MAX) begin
              w_state_next        = ST_LEVEL_UP;
              w_level_next        = w_level_inc;
              w_target_speed_next = SPEED_BASE + DXY_W'(w_level_inc);
            end
          end else begin
            w_win_count_next = r_win_count + WIN_W'(1);
          end
        end else if (i_round_done) begin
          if (r_lives <= LIVES_W'(1)) begin
            w_lives_next = '0;
            w_state_next = ST_GAME_OVER;
            if (w_score > r_high_score) begin
              w_high_score_next = w_score;
            end
          end else begin
            w_lives_next = r_lives - LIVES_W'(1);
          end
        end
      end
      ST_LEVEL_UP: begin
        w_state_next = ST_PLAY;
      end
      ST_GAME_OVER: begin
        if (w_key_rise && !i_end_of_game_timer_running) begin
          w_start = 1'b1;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase

    if (w_start) begin
      w_state_next        = ST_ARM;
      w_lives_next        = LIVES_START;
      w_level_next        = '0;
      w_win_count_next    = '0;
      w_target_speed_next = SPEED_BASE;
    end
  end

  assign w_score_clear = w_start;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state        <= ST_IDLE;
      r_key_q        <= 1'b0;
      r_win_count    <= '0;
      r_level        <= '0;
      r_lives        <= '0;
      r_high_score   <= '0;
      r_target_speed <= SPEED_BASE;
      r_master_hold  <= 1'b1;
      r_level_up     <= 1'b0;
      r_game_over    <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_key_q        <= i_key;
      r_win_count    <= w_win_count_next;
      r_level        <= w_level_next;
      r_lives        <= w_lives_next;
      r_high_score   <= w_high_score_next;
      r_target_speed <= w_target_speed_next;
      // Flag outputs decode the next state so they come straight from flops.
      r_master_hold  <= (w_state_next != ST_PLAY) && (w_state_next != ST_LEVEL_UP);
      r_level_up     <= (w_state_next == ST_LEVEL_UP);
      r_game_over    <= (w_state_next == ST_GAME_OVER);
    end
  end

  game_sat_counter #(
    .W(SCORE_W)
  ) u_score (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_clear   (w_score_clear),
    .i_inc     (w_score_inc),
    .o_count   (w_score)
  );

  assign o_master_hold  = r_master_hold;
  assign o_target_speed = r_target_speed;
  assign o_level        = r_level;
  assign o_lives        = r_lives;
  assign o_score        = w_score;
  assign o_high_score   = r_high_score;
  assign o_level_up     = r_level_up;
  assign o_game_over    = r_game_over;

endmodule
